// File: rtl/xcorr_lcd_formatter.sv
// xcorr_lcd_formatter: converts signed peak value and lag index to decimal ASCII LCD rows
// Ports: clk; reset_n (async, active-low); start/busy/done handshake;
//   max_val (signed) and max_pos (unsigned) are captured on an accepted start;
//   row_A = "Value" + sign + 10-digit field, row_B = "Max location" + 4-digit field.
module xcorr_lcd_formatter #(
   parameter int VAL_W = 31,
   parameter int POS_W = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [VAL_W-1:0] max_val,
   input  logic [POS_W-1:0] max_pos,
   output logic             busy,
   output logic             done,
   output logic [127:0]     row_A,
   output logic [127:0]     row_B
);
   localparam int CW = $clog2(VAL_W > POS_W ? VAL_W : POS_W);
   localparam logic [127:0] ROW_A_RST = "Press BTN0 to do";
   localparam logic [127:0] ROW_B_RST = "x-correlation...";
   typedef enum logic [1:0] {IDLE, CONV_V, CONV_P, PACK} state_t;
   state_t state, state_nxt;
   logic sign;
   logic [VAL_W-1:0] mag;
   logic [POS_W-1:0] pos;
   logic [39:0] bcd_v, adj_v;
   logic [15:0] bcd_p, adj_p;
   logic [CW-1:0] cnt;
   logic last;
   logic [79:0] txt_v;
   logic [31:0] txt_p;
   logic nz_v, nz_p;
   assign busy = state != IDLE;
   assign last = cnt == (state == CONV_V ? CW'(VAL_W - 1) : CW'(POS_W - 1));
   always_comb begin
      state_nxt = state == IDLE   ? (start ? CONV_V : IDLE) :
                  state == CONV_V ? (last ? CONV_P : CONV_V) :
                  state == CONV_P ? (last ? PACK : CONV_P) : IDLE;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nxt;
   // add-3 correction applied before each shift
   always_comb begin
      adj_v = bcd_v;
      adj_p = bcd_p;
      for (int i = 0; i < 10; i++)
         if (bcd_v[4*i +: 4] >= 4'd5) adj_v[4*i +: 4] = bcd_v[4*i +: 4] + 4'd3;
      for (int i = 0; i < 4; i++)
         if (bcd_p[4*i +: 4] >= 4'd5) adj_p[4*i +: 4] = bcd_p[4*i +: 4] + 4'd3;
   end
   // leading-zero blanking scans from the most significant digit; the last digit always prints
   always_comb begin
      txt_v = '0;
      txt_p = '0;
      nz_v = 1'b0;
      nz_p = 1'b0;
      for (int i = 9; i >= 0; i--) begin
         nz_v = nz_v | (bcd_v[4*i +: 4] != 4'd0) | (i == 0);
         txt_v[8*i +: 8] = nz_v ? {4'h3, bcd_v[4*i +: 4]} : 8'h20;
      end
      for (int i = 3; i >= 0; i--) begin
         nz_p = nz_p | (bcd_p[4*i +: 4] != 4'd0) | (i == 0);
         txt_p[8*i +: 8] = nz_p ? {4'h3, bcd_p[4*i +: 4]} : 8'h20;
      end
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         sign  <= 1'b0;
         mag   <= '0;
         pos   <= '0;
         bcd_v <= '0;
         bcd_p <= '0;
         cnt   <= '0;
         done  <= 1'b0;
         row_A <= ROW_A_RST;
         row_B <= ROW_B_RST;
      end else begin
         done <= state == PACK;
         if (state == IDLE && start) begin
            sign  <= max_val[VAL_W-1];
            // two's-complement negate; the most negative value maps to 2^(VAL_W-1) unsigned
            mag   <= max_val[VAL_W-1] ? -max_val : max_val;
            pos   <= max_pos;
            bcd_v <= '0;
            bcd_p <= '0;
            cnt   <= '0;
         end
         if (state == CONV_V) begin
            {bcd_v, mag} <= {adj_v, mag} << 1;
            cnt <= last ? '0 : cnt + CW'(1);
         end
         if (state == CONV_P) begin
            {bcd_p, pos} <= {adj_p, pos} << 1;
            cnt <= last ? '0 : cnt + CW'(1);
         end
         if (state == PACK) begin
            row_A <= {"Value", sign ? "-" : " ", txt_v};
            row_B <= {"Max location", txt_p};
         end
      end
endmodule

// File: tb/tb_xcorr_lcd_formatter.sv
// tb_xcorr_lcd_formatter: scoreboard bench for the decimal LCD row formatter
module tb_xcorr_lcd_formatter;
   localparam int VAL_W = 31;
   localparam int POS_W = 10;
   localparam logic [127:0] RST_A = "Press BTN0 to do";
   localparam logic [127:0] RST_B = "x-correlation...";
   typedef struct {
      logic [127:0] a;
      logic [127:0] b;
      int stamp;
   } exp_t;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic start = 1'b0;
   logic [VAL_W-1:0] max_val = '0;
   logic [POS_W-1:0] max_pos = '0;
   logic busy, done;
   logic [127:0] row_a, row_b;
   exp_t sb[$];
   exp_t cur;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int dones = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   xcorr_lcd_formatter #(.VAL_W(VAL_W), .POS_W(POS_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .max_val(max_val), .max_pos(max_pos),
      .busy(busy), .done(done), .row_A(row_a), .row_B(row_b)
   );
   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [127:0] to_row(input string s);
      logic [127:0] r = '0;
      for (int i = 0; i < 16; i++) r[8*(15-i) +: 8] = s[i];
      return r;
   endfunction
   function automatic exp_t mk(input int v, input int p, input int stamp);
      exp_t e;
      longint m = v < 0 ? -longint'(v) : longint'(v);
      e.a = to_row($sformatf("Value%s%10d", v < 0 ? "-" : " ", m));
      e.b = to_row($sformatf("Max location%4d", p));
      e.stamp = stamp;
      return e;
   endfunction
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic go(input int v, input int p);
      max_val = v[VAL_W-1:0];
      max_pos = p[POS_W-1:0];
      start = 1'b1;
      sb.push_back(mk(v, p, cyc + 1));
      tick;
      start = 1'b0;
   endtask
   task automatic drain;
      for (int i = 0; i < 150 && sb.size() > 0; i++) tick;
      check("drain", sb.size(), 0);
      sb.delete();
   endtask
   always @(negedge clk)
      if (done) begin
         dones++;
         if (sb.size() == 0) check("spurious_done", done, 0);
         else begin
            cur = sb.pop_front();
            check("row_a", row_a, cur.a);
            check("row_b", row_b, cur.b);
            check("latency", cyc - cur.stamp, 42);
            check("busy_at_done", busy, 0);
         end
      end
   initial begin
      repeat (2) tick;
      check("rst_busy", busy, 0);
      check("rst_row_a", row_a, RST_A);
      reset_n = 1'b1;
      tick;
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_row_a", row_a, RST_A);
      check("idle_row_b", row_b, RST_B);
      repeat (100) tick;
      check("idle100_row_a", row_a, RST_A);
      check("idle100_row_b", row_b, RST_B);
      check("idle100_dones", dones, 0);
      go(0, 0);
      drain;
      go(-12345, 37);
      drain;
      go(1073741823, 959);
      drain;
      go(-1073741824, 1023);
      drain;
      go(5, 1);
      repeat (9) tick;
      check("busy_mid", busy, 1);
      max_val = 31'd9;
      start = 1'b1;
      tick;
      start = 1'b0;
      drain;
      repeat (60) tick;
      check("single_done", dones, 5);
      max_val = 31'd77;
      max_pos = 10'd3;
      start = 1'b1;
      tick;
      start = 1'b0;
      repeat (19) tick;
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_row_a", row_a, RST_A);
      check("abort_row_b", row_b, RST_B);
      repeat (3) tick;
      reset_n = 1'b1;
      repeat (60) tick;
      check("abort_no_done", dones, 5);
      check("abort_row_a_kept", row_a, RST_A);
      max_val = 31'd42;
      max_pos = 10'd7;
      start = 1'b1;
      sb.push_back(mk(42, 7, cyc + 1));
      sb.push_back(mk(42, 7, cyc + 44));
      repeat (44) tick;
      start = 1'b0;
      drain;
      repeat (50) tick;
      check("held_dones", dones, 7);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
